// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared FSM encoding and default geometry for sync_ram_ctrl
package ram_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 4;

  // CLEAR is the reset state; IDLE accepts read/write/clear requests
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Even parity: stored parity bit makes the XOR of the whole word zero
  function automatic logic even_parity(input logic [DEFAULT_DATA_WIDTH-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/ram_array.sv
// rtl/ram_array.sv - word storage with one write port and a registered read port (optional parity via RAM_PARITY_EN)
import ram_pkg::*;

module ram_array #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rdata
`ifdef RAM_PARITY_EN
  ,
  output logic                  perr
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

`ifdef RAM_PARITY_EN
  // Top bit of each stored word is the even-parity bit over the data bits
  localparam int WORD_W = DATA_WIDTH + 1;
  logic [WORD_W-1:0] wword;
  assign wword = {^wdata, wdata};
`else
  localparam int WORD_W = DATA_WIDTH;
  logic [WORD_W-1:0] wword;
  assign wword = wdata;
`endif

  logic [WORD_W-1:0] mem [DEPTH];

  // Storage has no reset; the controller's clear sequence initialises it
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wword;
    end
  end

  // Registered read data holds its value between reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr][DATA_WIDTH-1:0];
    end
  end

`ifdef RAM_PARITY_EN
  // Parity error pulses on the cycle the faulty read data is presented
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perr <= 1'b0;
    end else begin
      perr <= re & (^mem[addr]);
    end
  end
`endif

endmodule

// File: rtl/sync_ram_ctrl.sv
// rtl/sync_ram_ctrl.sv - single-port RAM controller with clear sequencer and read/write arbitration (optional RAM_PARITY_EN)
import ram_pkg::*;

module sync_ram_ctrl #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic                  re,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  busy,
  output logic                  conflict
`ifdef RAM_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;

  logic                    mem_we;
  logic                    mem_re;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  // Arbitration: CLEAR owns the port; in IDLE clear outranks we/re and we+re together is dropped
  always_comb begin
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = addr;
    mem_wdata = din;
    if (state == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = clr_cnt;
      mem_wdata = '0;
    end else if (!clear) begin
      mem_we = we & ~re;
      mem_re = re & ~we;
    end
  end

  // Controller FSM with registered busy/valid/conflict outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_CLEAR;
      clr_cnt    <= '0;
      busy       <= 1'b1;
      dout_valid <= 1'b0;
      conflict   <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      conflict   <= 1'b0;
      case (state)
        ST_CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (clear) begin
            state   <= ST_CLEAR;
            busy    <= 1'b1;
            clr_cnt <= '0;
          end else begin
            dout_valid <= mem_re;
            conflict   <= we & re;
          end
        end
        default: begin
          state   <= ST_CLEAR;
          busy    <= 1'b1;
          clr_cnt <= '0;
        end
      endcase
    end
  end

  ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .addr  (mem_addr),
    .we    (mem_we),
    .wdata (mem_wdata),
    .re    (mem_re),
    .rdata (dout)
`ifdef RAM_PARITY_EN
    ,
    .perr  (parity_err)
`endif
  );

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// tb/tb_sync_ram_ctrl.sv - directed self-checking bench for sync_ram_ctrl (RAM_PARITY_EN adds the parity scenario)
`timescale 1ns/1ps

module tb_sync_ram_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] addr;
  logic       we;
  logic       re;
  logic [7:0] din;
  logic       clear;
  logic [7:0] dout;
  logic       dout_valid;
  logic       busy;
  logic       conflict;
`ifdef RAM_PARITY_EN
  logic       parity_err;
`endif

  int errors = 0;
  int checks = 0;

  sync_ram_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .we         (we),
    .re         (re),
    .din        (din),
    .clear      (clear),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .conflict   (conflict)
`ifdef RAM_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1ns past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; re = 1'b0; clear = 1'b0; din = 8'h00; addr = 4'h0;
  endtask

  // Count cycles until busy falls, bounded
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    idle_inputs();
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", dout); end
    checks++; if (dout_valid !== 1'b0 || conflict !== 1'b0) begin errors++; $display("FAIL reset_pulses: got valid=%b conflict=%b expected 0 0", dout_valid, conflict); end
    tick();
    reset = 1'b0;
    count_busy(n);
    checks++; if (n != 16) begin errors++; $display("FAIL reset_clear_len: got %0d cycles expected 16", n); end
    // Back-to-back reads of every address after the clear
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a); re = 1'b1;
      tick();
      checks++; if (dout_valid !== 1'b1 || dout !== 8'h00) begin errors++; $display("FAIL clear_read_%0d: got valid=%b dout=%h expected 1 00", a, dout_valid, dout); end
    end
    re = 1'b0;
    tick();
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL valid_drop: got %b expected 0", dout_valid); end
  endtask

  task automatic test_write_read();
    addr = 4'd3; din = 8'hA5; we = 1'b1;
    tick();
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL write_no_valid: got %b expected 0", dout_valid); end
    we = 1'b0; re = 1'b1;
    tick();
    checks++; if (dout_valid !== 1'b1 || dout !== 8'hA5) begin errors++; $display("FAIL read_after_write: got valid=%b dout=%h expected 1 a5", dout_valid, dout); end
    re = 1'b0;
    tick();
    checks++; if (dout_valid !== 1'b0 || dout !== 8'hA5) begin errors++; $display("FAIL dout_hold: got valid=%b dout=%h expected 0 a5", dout_valid, dout); end
  endtask

  task automatic test_conflict();
    addr = 4'd5; din = 8'h11; we = 1'b1;
    tick();
    din = 8'hFF; re = 1'b1;
    tick();
    checks++; if (conflict !== 1'b1) begin errors++; $display("FAIL conflict_pulse: got %b expected 1", conflict); end
    checks++; if (dout_valid !== 1'b0 || dout !== 8'hA5) begin errors++; $display("FAIL conflict_dout: got valid=%b dout=%h expected 0 a5", dout_valid, dout); end
    we = 1'b0; re = 1'b0;
    tick();
    checks++; if (conflict !== 1'b0) begin errors++; $display("FAIL conflict_one_cycle: got %b expected 0", conflict); end
    re = 1'b1;
    tick();
    checks++; if (dout !== 8'h11) begin errors++; $display("FAIL conflict_mem_kept: got %h expected 11", dout); end
    re = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [4];
    vals[0] = 8'h01; vals[1] = 8'h80; vals[2] = 8'h5A; vals[3] = 8'hFE;
    for (int i = 0; i < 4; i++) begin
      addr = 4'(8 + i); din = vals[i]; we = 1'b1;
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr = 4'(8 + i); re = 1'b1;
      tick();
      checks++; if (dout_valid !== 1'b1 || dout !== vals[i]) begin errors++; $display("FAIL b2b_read_%0d: got valid=%b dout=%h expected 1 %h", i, dout_valid, dout, vals[i]); end
    end
    re = 1'b0;
    tick();
  endtask

  task automatic test_clear();
    int n;
    int bad_valid;
    int bad_conf;
    addr = 4'd7; din = 8'h3C; we = 1'b1;
    tick();
    // clear wins over the simultaneous write to addr 7
    we = 1'b1; din = 8'h99; clear = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy: got %b expected 1", busy); end
    clear = 1'b0; we = 1'b1; re = 1'b1; din = 8'h77;
    bad_valid = 0; bad_conf = 0; n = 0;
    while (busy === 1'b1 && n < 40) begin
      re = n[0]; we = ~n[0];
      tick();
      n++;
      if (dout_valid === 1'b1) bad_valid++;
      if (conflict === 1'b1) bad_conf++;
    end
    we = 1'b0; re = 1'b0;
    checks++; if (n != 16) begin errors++; $display("FAIL clear_len: got %0d cycles expected 16", n); end
    checks++; if (bad_valid != 0 || bad_conf != 0) begin errors++; $display("FAIL clear_ignored: got valid=%0d conflict=%0d expected 0 0", bad_valid, bad_conf); end
    checks++; if (dout !== 8'hFE) begin errors++; $display("FAIL clear_dout_hold: got %h expected fe", dout); end
    addr = 4'd7; re = 1'b1;
    tick();
    checks++; if (dout_valid !== 1'b1 || dout !== 8'h00) begin errors++; $display("FAIL clear_read7: got valid=%b dout=%h expected 1 00", dout_valid, dout); end
    re = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_clear();
    int n;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b1 || dout !== 8'h00) begin errors++; $display("FAIL midclr_reset: got busy=%b dout=%h expected 1 00", busy, dout); end
    tick();
    reset = 1'b0;
    count_busy(n);
    checks++; if (n != 16) begin errors++; $display("FAIL midclr_len: got %0d cycles expected 16", n); end
  endtask

`ifdef RAM_PARITY_EN
  task automatic test_parity();
    addr = 4'd2; din = 8'h0F; we = 1'b1;
    tick();
    we = 1'b0;
    dut.u_array.mem[2] = dut.u_array.mem[2] ^ 9'h001;
    re = 1'b1;
    tick();
    checks++; if (parity_err !== 1'b1 || dout_valid !== 1'b1) begin errors++; $display("FAIL parity_bad: got perr=%b valid=%b expected 1 1", parity_err, dout_valid); end
    addr = 4'd3;
    tick();
    checks++; if (parity_err !== 1'b0 || dout_valid !== 1'b1) begin errors++; $display("FAIL parity_clean: got perr=%b valid=%b expected 0 1", parity_err, dout_valid); end
    re = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_conflict();
    test_back_to_back();
    test_clear();
`ifdef RAM_PARITY_EN
    test_parity();
`endif
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
